// File: rtl/fetch_unit_pkg.sv
// Shared widths, stall encoding, reset PC and bus layouts for the fetch stage.
package fetch_unit_pkg;

  localparam int STALL_W     = 2;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  // stall vector bit positions and the two stall levels
  localparam int   STALL_PC = 0;
  localparam int   STALL_ID = 1;
  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;

  localparam logic [31:0] FETCH_RESET_PC = 32'hBFBF_FFFC;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'h4;
  endfunction

endpackage

// File: rtl/fetch_unit_hold_buf.sv
// Holds the SRAM instruction while decode is stalled, so the word read in the
// first stall cycle is not lost when the SRAM output moves on.
module fetch_unit_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic [31:0] rdata_in,
  output logic [31:0] inst_out
);

  logic        hold_valid;
  logic [31:0] hold_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'h0;
    end else if (stall_id == STOP) begin
      // capture only on the first stall cycle; later cycles keep that word
      if (!hold_valid) begin
        hold_valid <= 1'b1;
        hold_inst  <= rdata_in;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

  assign inst_out = hold_valid ? hold_inst : rdata_in;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, redirect handling across stalls, SRAM interface.
// Optional misaligned-fetch check is enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            id_inst,
  output logic                   fetch_adel
);

  br_bus_t     br;
  if_to_id_t   to_id;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pend_addr;
  logic        ce;
  logic        br_pend;
  logic        adel;

  assign br = br_bus_t'(br_bus);

  always_comb begin
    next_pc = seq_pc(pc);
    if (br.br_e) begin
      next_pc = br.br_addr;
    end else if (br_pend) begin
      next_pc = pend_addr;
    end
  end

  // A redirect arriving while the PC is stalled is parked until the stall lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= FETCH_RESET_PC;
      ce        <= 1'b0;
      br_pend   <= 1'b0;
      pend_addr <= 32'h0;
    end else if (stall[STALL_PC] == NO_STOP) begin
      pc      <= next_pc;
      ce      <= 1'b1;
      br_pend <= 1'b0;
    end else if (br.br_e) begin
      br_pend   <= 1'b1;
      pend_addr <= br.br_addr;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  assign adel = ce & (pc[1:0] != 2'b00);
`else
  assign adel = 1'b0;
`endif

  assign fetch_adel      = adel;
  assign inst_sram_en    = ce & ~adel;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'h0;

  assign to_id.ce = ce & ~adel;
  assign to_id.pc = pc;
  assign if_to_id_bus = to_id;

  fetch_unit_hold_buf inst_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .stall_id (stall[STALL_ID]),
    .rdata_in (inst_sram_rdata),
    .inst_out (id_inst)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, redirects, stalls,
// hold buffer and misaligned-fetch behaviour.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic [32:0] br_bus;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] id_inst;
  logic        fetch_adel;

  int          total;
  int          bad;
  logic [31:0] exp_pc;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .if_to_id_bus    (if_to_id_bus),
    .id_inst         (id_inst),
    .fetch_adel      (fetch_adel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    stall = 2'b00;
    br_bus = 33'h0;
    inst_sram_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (inst_sram_addr !== 32'hBFBF_FFFC) begin
      bad++; $display("FAIL reset_pc got=%h exp=%h", inst_sram_addr, 32'hBFBF_FFFC);
    end
    total++;
    if (inst_sram_en !== 1'b0) begin
      bad++; $display("FAIL reset_en got=%b exp=0", inst_sram_en);
    end
    total++;
    if (if_to_id_bus !== 33'h0_BFBF_FFFC) begin
      bad++; $display("FAIL reset_bus got=%h exp=%h", if_to_id_bus, 33'h0_BFBF_FFFC);
    end
    total++;
    if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_wr got=%h/%h exp=0/0", inst_sram_wen, inst_sram_wdata);
    end
    total++;
    if (id_inst !== 32'hDEAD_BEEF || fetch_adel !== 1'b0) begin
      bad++; $display("FAIL reset_id got=%h adel=%b exp=deadbeef adel=0", id_inst, fetch_adel);
    end
    rst = 1'b0;
    exp_pc = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (inst_sram_addr !== exp_pc || inst_sram_en !== 1'b1) begin
        bad++; $display("FAIL boot_seq%0d got=%h en=%b exp=%h en=1", i, inst_sram_addr, inst_sram_en, exp_pc);
      end
      total++;
      if (if_to_id_bus !== {1'b1, exp_pc}) begin
        bad++; $display("FAIL boot_bus%0d got=%h exp=%h", i, if_to_id_bus, {1'b1, exp_pc});
      end
      exp_pc = exp_pc + 32'h4;
    end
    exp_pc = exp_pc - 32'h4;
  endtask

  task automatic test_redirect();
    @(negedge clk);
    exp_pc = exp_pc + 32'h4;
    br_bus = {1'b1, 32'hBFC0_0100};
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL redir_slot got=%h exp=%h", inst_sram_addr, exp_pc);
    end
    @(negedge clk);
    br_bus = 33'h0;
    exp_pc = 32'hBFC0_0100;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL redir_target got=%h exp=%h", inst_sram_addr, exp_pc);
    end
    @(negedge clk);
    exp_pc = 32'hBFC0_0104;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL redir_after got=%h exp=%h", inst_sram_addr, exp_pc);
    end
  endtask

  task automatic test_stall_redirect();
    @(negedge clk);
    exp_pc = exp_pc + 32'h4;
    stall = 2'b11;
    br_bus = {1'b1, 32'hBFC0_0200};
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL stall_br_c0 got=%h exp=%h", inst_sram_addr, exp_pc);
    end
    @(negedge clk);
    br_bus = 33'h0;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc || dut.br_pend !== 1'b1) begin
      bad++; $display("FAIL stall_br_c1 got=%h pend=%b exp=%h pend=1", inst_sram_addr, dut.br_pend, exp_pc);
    end
    @(negedge clk);
    stall = 2'b00;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc || dut.br_pend !== 1'b1) begin
      bad++; $display("FAIL stall_br_rel got=%h pend=%b exp=%h pend=1", inst_sram_addr, dut.br_pend, exp_pc);
    end
    @(negedge clk);
    exp_pc = 32'hBFC0_0200;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc || dut.br_pend !== 1'b0) begin
      bad++; $display("FAIL stall_br_tgt got=%h pend=%b exp=%h pend=0", inst_sram_addr, dut.br_pend, exp_pc);
    end
    @(negedge clk);
    exp_pc = 32'hBFC0_0204;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL stall_br_seq got=%h exp=%h", inst_sram_addr, exp_pc);
    end
  endtask

  task automatic test_pend_overwrite();
    @(negedge clk);
    exp_pc = exp_pc + 32'h4;
    stall = 2'b01;
    br_bus = {1'b1, 32'hBFC0_0300};
    @(negedge clk);
    br_bus = {1'b1, 32'hBFC0_0400};
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL ovw_hold got=%h exp=%h", inst_sram_addr, exp_pc);
    end
    @(negedge clk);
    br_bus = 33'h0;
    stall = 2'b00;
    @(negedge clk);
    exp_pc = 32'hBFC0_0400;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL ovw_target got=%h exp=%h", inst_sram_addr, exp_pc);
    end
  endtask

  task automatic test_hold_buf();
    logic [31:0] exp_id [5];
    logic [31:0] rd [5];
    logic [1:0]  st [5];
    rd[0] = 32'h2408_0001; st[0] = 2'b10; exp_id[0] = 32'h2408_0001;
    rd[1] = 32'h1111_1111; st[1] = 2'b10; exp_id[1] = 32'h2408_0001;
    rd[2] = 32'h1111_1111; st[2] = 2'b10; exp_id[2] = 32'h2408_0001;
    rd[3] = 32'h1111_1111; st[3] = 2'b00; exp_id[3] = 32'h2408_0001;
    rd[4] = 32'h3333_3333; st[4] = 2'b00; exp_id[4] = 32'h3333_3333;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_pc = exp_pc + 32'h4;
      stall = st[i];
      inst_sram_rdata = rd[i];
      #1;
      total++;
      if (id_inst !== exp_id[i]) begin
        bad++; $display("FAIL hold_id%0d got=%h exp=%h", i, id_inst, exp_id[i]);
      end
      total++;
      if (inst_sram_addr !== exp_pc) begin
        bad++; $display("FAIL hold_pc%0d got=%h exp=%h", i, inst_sram_addr, exp_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    stall = 2'b11;
    br_bus = {1'b1, 32'hBFC0_0500};
    inst_sram_rdata = 32'hAAAA_5555;
    @(negedge clk);
    br_bus = 33'h0;
    #1;
    total++;
    if (dut.br_pend !== 1'b1 || id_inst !== 32'hAAAA_5555) begin
      bad++; $display("FAIL rmid_pre pend=%b id=%h exp pend=1 id=aaaa5555", dut.br_pend, id_inst);
    end
    rst = 1'b1;
    @(negedge clk);
    inst_sram_rdata = 32'h1234_5678;
    #1;
    total++;
    if (inst_sram_addr !== 32'hBFBF_FFFC || inst_sram_en !== 1'b0) begin
      bad++; $display("FAIL rmid_pc got=%h en=%b exp=bfbffffc en=0", inst_sram_addr, inst_sram_en);
    end
    total++;
    if (dut.br_pend !== 1'b0 || id_inst !== 32'h1234_5678) begin
      bad++; $display("FAIL rmid_state pend=%b id=%h exp pend=0 id=12345678", dut.br_pend, id_inst);
    end
    rst = 1'b0;
    stall = 2'b00;
    @(negedge clk);
    exp_pc = 32'hBFC0_0000;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc || inst_sram_en !== 1'b1) begin
      bad++; $display("FAIL rmid_boot got=%h en=%b exp=%h en=1", inst_sram_addr, inst_sram_en, exp_pc);
    end
    @(negedge clk);
    exp_pc = 32'hBFC0_0004;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL rmid_seq got=%h exp=%h", inst_sram_addr, exp_pc);
    end
  endtask

  task automatic test_adel();
    logic exp_adel;
`ifdef FETCH_ADEL_CHECK_EN
    exp_adel = 1'b1;
`else
    exp_adel = 1'b0;
`endif
    @(negedge clk);
    br_bus = {1'b1, 32'hBFC0_0102};
    @(negedge clk);
    br_bus = 33'h0;
    exp_pc = 32'hBFC0_0102;
    #1;
    total++;
    if (inst_sram_addr !== exp_pc) begin
      bad++; $display("FAIL adel_pc got=%h exp=%h", inst_sram_addr, exp_pc);
    end
    total++;
    if (fetch_adel !== exp_adel || inst_sram_en !== ~exp_adel) begin
      bad++; $display("FAIL adel_flag got=%b en=%b exp=%b en=%b", fetch_adel, inst_sram_en, exp_adel, ~exp_adel);
    end
    total++;
    if (if_to_id_bus !== {~exp_adel, exp_pc}) begin
      bad++; $display("FAIL adel_bus got=%h exp=%h", if_to_id_bus, {~exp_adel, exp_pc});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_pc = 32'h0;
    test_reset();
    test_redirect();
    test_stall_redirect();
    test_pend_overwrite();
    test_hold_buf();
    test_reset_mid();
    test_adel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
